// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared state type, control-word layout and packing helper
// for the enemy spawner.
package enemy_pkg;

   typedef enum logic [1:0] {IDLE, STAGGER, RUN} spawner_state_t;

   localparam int CTRL_COL_LSB  = 0;
   localparam int CTRL_COL_W    = 10;
   localparam int CTRL_FLIP_BIT = 10;
   localparam int CTRL_SPD_LSB  = 11;
   localparam int CTRL_SPD_W    = 2;

   function automatic logic [15:0] pack_ctrl(input logic [CTRL_COL_W-1:0] col,
                                             input logic                  flip,
                                             input logic [CTRL_SPD_W-1:0] spd);
      logic [15:0] w;
      w = '0;
      w[CTRL_COL_LSB +: CTRL_COL_W] = col;
      w[CTRL_FLIP_BIT]              = flip;
      w[CTRL_SPD_LSB +: CTRL_SPD_W] = spd;
      return w;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11) with advance enable.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        adv,
   output logic [15:0] q
);

   logic fb;
   assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= SEED;
      else if (adv)
         q <= {q[14:0], fb};
   end

endmodule

// File: rtl/enemy_spawner.sv
// rtl/enemy_spawner.sv - staggered enemy release, rolling control-word refresh and
// difficulty ramp; SPAWNER_SIDE_BALANCE_EN selects alternating spawn sides.
module enemy_spawner
   import enemy_pkg::*;
#(
   parameter int          NUM_ENEMIES    = 4,
   parameter int          SPAWN_INTERVAL = 60,
   parameter int          LEVEL_FRAMES   = 600,
   parameter logic [15:0] SEED           = 16'hACE1
) (
   input  logic                      frame_clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      pause,
   input  logic                      game_over,
   output logic [NUM_ENEMIES-1:0]    en,
   output logic [16*NUM_ENEMIES-1:0] control,
   output logic [1:0]                level,
   output logic                      active
);

   localparam int PW  = (NUM_ENEMIES > 1)    ? $clog2(NUM_ENEMIES)    : 1;
   localparam int SCW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
   localparam int LCW = (LEVEL_FRAMES > 1)   ? $clog2(LEVEL_FRAMES)   : 1;

   spawner_state_t         state;
   logic [NUM_ENEMIES-1:0] en_mask;
   logic                   pause_q;
   logic [PW-1:0]          ptr;
   logic [PW-1:0]          rel_idx;
   logic [SCW-1:0]         rel_cnt;
   logic [LCW-1:0]         level_cnt;
   logic [15:0]            lfsr_q;
   logic                   flip_bit;
   logic                   running;
   logic                   frozen;
   logic                   refresh;

   assign running = (state != IDLE);
   assign frozen  = pause & ~game_over & running;
   // The start edge itself refreshes a word, so enemy 0 has fresh data on release.
   assign refresh = ~game_over & ~frozen & (running | start);
   assign en      = en_mask & ~{NUM_ENEMIES{pause_q & running}};

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk (frame_clk),
      .rst (rst),
      .adv (~frozen),
      .q   (lfsr_q)
   );

`ifdef SPAWNER_SIDE_BALANCE_EN
   logic side_t;
   logic lfsr_unused;
   assign lfsr_unused = ^lfsr_q[15:10];
   assign flip_bit    = side_t;

   always_ff @(posedge frame_clk or posedge rst) begin
      if (rst)
         side_t <= 1'b1;
      else if (refresh)
         side_t <= ~side_t;
   end
`else
   logic lfsr_unused;
   assign lfsr_unused = ^lfsr_q[15:11];
   assign flip_bit    = lfsr_q[10];
`endif

   always_ff @(posedge frame_clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         active    <= 1'b0;
         en_mask   <= '0;
         control   <= '0;
         level     <= 2'd0;
         pause_q   <= 1'b0;
         ptr       <= '0;
         rel_idx   <= '0;
         rel_cnt   <= '0;
         level_cnt <= '0;
      end else begin
         pause_q <= pause;
         if (refresh) begin
            control[ptr*16 +: 16] <= pack_ctrl(lfsr_q[CTRL_COL_W-1:0], flip_bit, level);
            ptr <= (ptr == PW'(NUM_ENEMIES-1)) ? '0 : ptr + PW'(1);
         end
         if (game_over) begin
            state   <= IDLE;
            active  <= 1'b0;
            en_mask <= '0;
            level   <= 2'd0;
         end else if (!frozen) begin
            case (state)
               IDLE: begin
                  if (start) begin
                     en_mask   <= NUM_ENEMIES'(1);
                     rel_idx   <= PW'(1);
                     rel_cnt   <= '0;
                     level_cnt <= '0;
                     level     <= 2'd0;
                     state     <= (NUM_ENEMIES == 1) ? RUN : STAGGER;
                     active    <= 1'b1;
                  end
               end
               STAGGER, RUN: begin
                  if (level != 2'd3) begin
                     if (level_cnt == LCW'(LEVEL_FRAMES-1)) begin
                        level     <= level + 2'd1;
                        level_cnt <= '0;
                     end else begin
                        level_cnt <= level_cnt + LCW'(1);
                     end
                  end
                  if (state == STAGGER) begin
                     if (rel_cnt == SCW'(SPAWN_INTERVAL-1)) begin
                        en_mask[rel_idx] <= 1'b1;
                        rel_idx          <= rel_idx + PW'(1);
                        rel_cnt          <= '0;
                        if (rel_idx == PW'(NUM_ENEMIES-1))
                           state <= RUN;
                     end else begin
                        rel_cnt <= rel_cnt + SCW'(1);
                     end
                  end
               end
               default: begin
                  state  <= IDLE;
                  active <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_enemy_spawner.sv
// tb/tb_enemy_spawner.sv - directed and randomized checks of enemy_spawner against
// a frame-count reference model.
`timescale 1ns/1ps
module tb_enemy_spawner;

   localparam int N  = 4;
   localparam int SI = 2;
   localparam int LF = 8;

   logic            frame_clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            pause = 1'b0;
   logic            game_over = 1'b0;
   logic [N-1:0]    en;
   logic [16*N-1:0] control;
   logic [1:0]      level;
   logic            active;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: the game is described by the count of unfrozen frames since start.
   bit          m_run;
   int          m_t;
   int          m_ptr;
   bit [15:0]   m_lfsr;
   bit [15:0]   m_ctrl [N];
   bit          m_pq;
   bit          m_side;

   enemy_spawner #(.NUM_ENEMIES(N), .SPAWN_INTERVAL(SI), .LEVEL_FRAMES(LF),
                   .SEED(16'hACE1)) dut (
      .frame_clk (frame_clk),
      .rst       (rst),
      .start     (start),
      .pause     (pause),
      .game_over (game_over),
      .en        (en),
      .control   (control),
      .level     (level),
      .active    (active)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_level();
      int l;
      if (!m_run) return 0;
      l = m_t / LF;
      return (l > 3) ? 3 : l;
   endfunction

   function automatic int m_released();
      int r;
      if (!m_run) return 0;
      r = 1 + m_t / SI;
      return (r > N) ? N : r;
   endfunction

   function automatic bit [15:0] lfsr_step(input bit [15:0] x);
      int fb;
      fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
      return 16'((int'(x) << 1) | fb);
   endfunction

   task automatic model_reset();
      m_run = 0; m_t = 0; m_ptr = 0; m_lfsr = 16'hACE1; m_pq = 0; m_side = 1;
      for (int i = 0; i < N; i++) m_ctrl[i] = '0;
   endtask

   task automatic model_edge(input bit s, input bit p, input bit g);
      bit frz, rf, flip;
      int lv;
      frz = p && !g && m_run;
      rf  = !g && !frz && (m_run || s);
      if (rf) begin
`ifdef SPAWNER_SIDE_BALANCE_EN
         flip = m_side;
         m_side = !m_side;
`else
         flip = m_lfsr[10];
`endif
         lv = m_level();
         m_ctrl[m_ptr] = 16'((lv << 11) | (int'(flip) << 10) | (m_lfsr & 16'h03FF));
         m_ptr = (m_ptr + 1) % N;
      end
      if (!frz) m_lfsr = lfsr_step(m_lfsr);
      if (g) begin
         m_run = 0;
      end else if (!frz) begin
         if (m_run) m_t++;
         else if (s) begin m_run = 1; m_t = 0; end
      end
      m_pq = p;
   endtask

   task automatic check_all();
      logic [63:0] ec;
      int          exp_en;
      ec = '0;
      for (int i = 0; i < N; i++) ec[16*i +: 16] = m_ctrl[i];
      exp_en = (m_run && !m_pq) ? ((1 << m_released()) - 1) : 0;
      chk("en", 64'(en), 64'(exp_en));
      chk("control", 64'(control), ec);
      chk("level", 64'(level), 64'(m_level()));
      chk("active", 64'(active), 64'(m_run));
      chk("lfsr", 64'(dut.lfsr_q), 64'(m_lfsr));
   endtask

   task automatic step(input bit s, input bit p, input bit g);
      start = s; pause = p; game_over = g;
      @(posedge frame_clk);
      model_edge(s, p, g);
      @(negedge frame_clk);
      check_all();
   endtask

   initial begin
      bit rs, rp, rg;
      model_reset();
      @(negedge frame_clk);
      @(negedge frame_clk);
      chk("reset_en", 64'(en), 64'(0));
      chk("reset_control", 64'(control), 64'(0));
      chk("reset_level", 64'(level), 64'(0));
      chk("reset_active", 64'(active), 64'(0));
      rst = 1'b0;

      // Start on the first edge after reset release.
      step(1, 0, 0);
      chk("first_word", 64'(control[15:0]), 64'h04E1);
      chk("first_en", 64'(en), 64'h1);
      chk("first_active", 64'(active), 64'h1);
      chk("first_lfsr", 64'(dut.lfsr_q), 64'h59C3);

      for (int e = 2; e <= 41; e++) begin
         step(e == 2, 0, 0);
         if (e == 3)  chk("stagger_e3", 64'(en), 64'h3);
         if (e == 5)  chk("stagger_e5", 64'(en), 64'h7);
         if (e == 7)  chk("stagger_e7", 64'(en), 64'hF);
         if (e == 9)  chk("level_8", 64'(level), 64'd1);
         if (e == 17) chk("level_16", 64'(level), 64'd2);
         if (e == 25) chk("level_24", 64'(level), 64'd3);
         if (e == 41) chk("level_40", 64'(level), 64'd3);
      end

      // game_over beats pause and start.
      step(1, 1, 1);
      chk("gover_en", 64'(en), 64'h0);
      chk("gover_level", 64'(level), 64'h0);
      chk("gover_active", 64'(active), 64'h0);
      step(1, 0, 0);
      chk("restart_en", 64'(en), 64'h1);

      // Pause for 5 frames starting at edge 4 delays release by 5 frames.
      step(0, 0, 0);
      step(0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0);
         chk("paused_en", 64'(en), 64'h0);
      end
      step(0, 0, 0);
      chk("resume_e9", 64'(en), 64'h3);
      step(0, 0, 0);
      chk("resume_e10", 64'(en), 64'h7);

      // Randomized play with an asynchronous reset dropped in midway.
      rp = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            #2 rst = 1'b1;
            #1;
            chk("async_rst_en", 64'(en), 64'h0);
            chk("async_rst_active", 64'(active), 64'h0);
            chk("async_rst_control", 64'(control), 64'h0);
            model_reset();
            @(negedge frame_clk);
            rst = 1'b0;
         end
         if ($urandom_range(0, 11) == 0) rp = !rp;
         rs = ($urandom_range(0, 9) == 0);
         rg = ($urandom_range(0, 149) == 0);
         step(rs, rp, rg);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
